// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between N requesters and the round-robin mux arbiter.
interface mux_rr_arbiter_if #(
    parameter int NUM_OF_INPUTS = 5,
    parameter int SEL_W         = $clog2(NUM_OF_INPUTS)
);
    logic [NUM_OF_INPUTS-1:0] req;
    logic                     done;
    logic [NUM_OF_INPUTS-1:0] gnt;
    logic [SEL_W-1:0]         sel;
    logic                     busy;
    logic                     tmo;

    modport master (output req, done, input gnt, sel, busy, tmo);
    modport slave  (input req, done, output gnt, sel, busy, tmo);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 mux, with one-hot
// grant, owner release via done/req-drop and an optional hold timeout.
module mux_rr_arbiter #(
    parameter int NUM_OF_INPUTS = 5,
    parameter int MAX_HOLD      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);
    localparam int SEL_W     = $clog2(NUM_OF_INPUTS);
    localparam int HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                   state;
    logic [SEL_W-1:0]         ptr;
    logic [SEL_W-1:0]         sel;
    logic [HC_W-1:0]          hold_cnt;
    logic [NUM_OF_INPUTS-1:0] gnt;
    logic                     busy;
    logic                     tmo;

    logic [SEL_W-1:0]         win;
    logic                     timeout;
    logic                     owner_drop;
    logic                     rel;

    // Scan from ptr upward; wrap against NUM_OF_INPUTS, not the SEL_W rollover.
    always_comb begin
        logic [SEL_W:0] idx;
        logic           found;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_OF_INPUTS; i++) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(i);
            if (idx >= (SEL_W+1)'(NUM_OF_INPUTS))
                idx = idx - (SEL_W+1)'(NUM_OF_INPUTS);
            if (!found && bus.req[idx[SEL_W-1:0]]) begin
                win   = idx[SEL_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HC_W'(HOLD_LAST));
    assign owner_drop = !bus.req[sel];
    assign rel        = bus.done || owner_drop || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            tmo <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt      <= NUM_OF_INPUTS'(1) << win;
                        sel      <= win;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HC_W'(MAX_HOLD))
                        hold_cnt <= hold_cnt + 1'b1;
                    if (rel) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                        ptr   <= (sel == SEL_W'(NUM_OF_INPUTS-1)) ? '0 : sel + 1'b1;
                        // Timeout flag only when nothing else would have released.
                        tmo   <= timeout && !bus.done && !owner_drop;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt;
    assign bus.sel  = sel;
    assign bus.busy = busy;
    assign bus.tmo  = tmo;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with NUM_OF_INPUTS=5, MAX_HOLD=4.
module tb_mux_rr_arbiter;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.NUM_OF_INPUTS(N)) bus ();

    mux_rr_arbiter #(.NUM_OF_INPUTS(N), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] s,
                           input logic b, input logic t);
        chk({tag, ".gnt"},  32'(bus.gnt),  32'(g));
        chk({tag, ".sel"},  32'(bus.sel),  32'(s));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".tmo"},  32'(bus.tmo),  32'(t));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        #1;
        chk_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
        do_reset();

        // 1: single requester, done release, pointer moves to 3
        bus.req = 5'b00100;
        step();
        chk_out("t1_grant", 5'b00100, 3'd2, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        chk_out("t1_rel", 5'b00000, 3'd2, 1'b0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 5'b00101;
        step();
        chk_out("t1_ptr3", 5'b00001, 3'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 5'b00000;

        // 2: all requesting from ptr=0, one idle cycle between grants
        do_reset();
        bus.req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk_out($sformatf("t2_g%0d", k), 5'(1 << (k % N)), 3'(k % N), 1'b1, 1'b0);
            bus.done = 1'b1;
            step();
            chk_out($sformatf("t2_gap%0d", k), 5'b00000, 3'(k % N), 1'b0, 1'b0);
            bus.done = 1'b0;
            if (k == 5) bus.req = 5'b01000;
        end

        // 3: owner 3 never releases -> 4 granted cycles then timeout
        step();
        chk_out("t3_g0", 5'b01000, 3'd3, 1'b1, 1'b0);
        for (int c = 1; c < 4; c++) begin
            step();
            chk_out($sformatf("t3_g%0d", c), 5'b01000, 3'd3, 1'b1, 1'b0);
        end
        step();
        chk_out("t3_tmo", 5'b00000, 3'd3, 1'b0, 1'b1);

        // 4: ptr=4 wraps to input 0; owner drop releases without tmo
        bus.req = 5'b00011;
        step();
        chk_out("t4_wrap", 5'b00001, 3'd0, 1'b1, 1'b0);
        bus.req = 5'b00010;
        step();
        chk_out("t4_drop", 5'b00000, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("t4_next", 5'b00010, 3'd1, 1'b1, 1'b0);

        // 5: async reset mid-grant clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5_async", 5'b00000, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("t5_held", 5'b00000, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("t5_regrant", 5'b00010, 3'd1, 1'b1, 1'b0);

        // 6: done while idle is ignored; done coinciding with timeout gives no tmo
        bus.done = 1'b1;
        bus.req  = 5'b00000;
        step();
        chk_out("t6_rel", 5'b00000, 3'd1, 1'b0, 1'b0);
        step();
        step();
        chk_out("t6_idle_done", 5'b00000, 3'd1, 1'b0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 5'b00100;
        step();
        chk_out("t6_g0", 5'b00100, 3'd2, 1'b1, 1'b0);
        repeat (3) step();
        chk_out("t6_g3", 5'b00100, 3'd2, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        chk_out("t6_done_tmo", 5'b00000, 3'd2, 1'b0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 5'b00000;
        step();
        chk_out("t6_quiet", 5'b00000, 3'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
